// File: rtl/swi_monitor_pkg.sv
// Shared types and default sizing for the switch-writable register bank monitor.
package swi_monitor_pkg;

  typedef enum logic [1:0] {
    ModeManual = 2'd0,
    ModeAuto   = 2'd1,
    ModeFreeze = 2'd2,
    ModeClear  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StClear = 2'd2,
    StDone  = 2'd3
  } state_t;

  localparam int unsigned DefNbits    = 8;
  localparam int unsigned DefNregs    = 32;
  localparam int unsigned DefNbitsLcd = 64;
  localparam int unsigned DefScanDiv  = 4;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: one-cycle pulse on each low-to-high transition of din.
module edge_detect (
  input  logic clk_2,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic din_q;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/swi_reg_bank_monitor.sv
// Switch-writable register bank with auto-scan, clear engine, write history and
// accepted/dropped write statistics feeding the LCD, LED and 7-seg outputs.
module swi_reg_bank_monitor
  import swi_monitor_pkg::*;
#(
  parameter int unsigned NBITS     = DefNbits,
  parameter int unsigned NREGS     = DefNregs,
  parameter int unsigned NBITS_LCD = DefNbitsLcd,
  parameter int unsigned SCAN_DIV  = DefScanDiv
) (
  input  logic                       clk_2,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(NREGS)-1:0]   wr_addr,
  input  logic [NBITS-1:0]           wr_data,
  input  logic [1:0]                 mode,
  output logic [NBITS-1:0]           LED,
  output logic [NBITS-1:0]           SEG,
  output logic [NBITS-1:0]           lcd_registrador [0:NREGS-1],
  output logic [NBITS-1:0]           lcd_pc,
  output logic [NBITS_LCD-1:0]       lcd_a,
  output logic [NBITS_LCD-1:0]       lcd_b,
  output logic                       busy
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned HW = NBITS_LCD / 2;
  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] IDLE  = StIdle;
  localparam logic [1:0] SCAN  = StScan;
  localparam logic [1:0] CLEAR = StClear;
  localparam logic [1:0] DONE  = StDone;

  mode_t             mode_e;
  logic              pulse;
  logic              accept;
  logic              drop;
  logic [1:0]        state, state_next;
  logic [AW-1:0]     sel, sel_next;
  logic [AW-1:0]     clr_ptr, clr_ptr_next;
  logic [DW-1:0]     div, div_next;
  logic [NBITS-1:0]  regs [NREGS];
  logic [NBITS_LCD-1:0] history;
  logic [HW-1:0]     acc_cnt;
  logic [HW-1:0]     drop_cnt;
  logic              busy_q;

  assign mode_e = mode_t'(mode);

  edge_detect u_wr_edge (
    .clk_2 (clk_2),
    .reset (reset),
    .din   (wr_en),
    .pulse (pulse)
  );

  assign accept = pulse && (state != CLEAR) && (mode_e != ModeFreeze);
  assign drop   = pulse && !accept;

  always_comb begin
    state_next   = state;
    sel_next     = sel;
    div_next     = div;
    clr_ptr_next = clr_ptr;
    unique case (state)
      IDLE: begin
        if (mode_e == ModeAuto) begin
          state_next = SCAN;
          div_next   = '0;
        end else if (mode_e == ModeClear) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end else if (mode_e == ModeManual) begin
          sel_next = wr_addr;
        end
      end
      SCAN: begin
        // Leaving AUTO keeps sel; MANUAL reloads it from IDLE on the next cycle.
        if (mode_e != ModeAuto) begin
          state_next = IDLE;
        end else if (div == DW'(SCAN_DIV - 1)) begin
          div_next = '0;
          sel_next = sel + AW'(1);
        end else begin
          div_next = div + DW'(1);
        end
      end
      CLEAR: begin
        clr_ptr_next = clr_ptr + AW'(1);
        if (clr_ptr == AW'(NREGS - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (mode_e != ModeClear) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= '0;
      div      <= '0;
      clr_ptr  <= '0;
      busy_q   <= 1'b0;
      history  <= '0;
      acc_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state   <= state_next;
      sel     <= sel_next;
      div     <= div_next;
      clr_ptr <= clr_ptr_next;
      busy_q  <= (state_next == CLEAR);
      if (accept) begin
        history <= {history[NBITS_LCD-NBITS-1:0], wr_data};
        acc_cnt <= acc_cnt + HW'(1);
      end
      if (drop) begin
        drop_cnt <= drop_cnt + HW'(1);
      end
    end
  end

  // Writes are always dropped while clearing, so the two never target one entry.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (state == CLEAR) begin
      regs[clr_ptr] <= '0;
    end else if (accept) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign lcd_registrador = regs;
  assign LED             = regs[sel];
  assign SEG             = NBITS'(sel);
  assign lcd_pc          = NBITS'(sel);
  assign lcd_a           = history;
  assign lcd_b           = {acc_cnt, drop_cnt};
  assign busy            = busy_q;

endmodule

// File: tb/tb_swi_reg_bank_monitor.sv
// Directed scoreboard bench for swi_reg_bank_monitor with default parameters.
module tb_swi_reg_bank_monitor;

  logic        clk_2 = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  mode;
  logic [7:0]  LED;
  logic [7:0]  SEG;
  logic [7:0]  lcd_registrador [0:31];
  logic [7:0]  lcd_pc;
  logic [63:0] lcd_a;
  logic [63:0] lcd_b;
  logic        busy;

  int          vectors = 0;
  int          miscompares = 0;
  string       tag_q[$];
  logic [63:0] exp_q[$];
  int          nbusy;
  logic [7:0]  orv;

  swi_reg_bank_monitor #(
    .NBITS     (8),
    .NREGS     (32),
    .NBITS_LCD (64),
    .SCAN_DIV  (4)
  ) dut (
    .clk_2           (clk_2),
    .reset           (reset),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .mode            (mode),
    .LED             (LED),
    .SEG             (SEG),
    .lcd_registrador (lcd_registrador),
    .lcd_pc          (lcd_pc),
    .lcd_a           (lcd_a),
    .lcd_b           (lcd_b),
    .busy            (busy)
  );

  always #5 clk_2 = ~clk_2;

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  task automatic push(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [63:0] obs);
    string       tag;
    logic [63:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_underflow observed=%h expected=none", obs);
      return;
    end
    tag = tag_q.pop_front();
    e   = exp_q.pop_front();
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  function automatic logic [7:0] or_all();
    logic [7:0] r = '0;
    for (int i = 0; i < 32; i++) r |= lcd_registrador[i];
    return r;
  endfunction

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; mode = 2'd0;
    step(2);
    push("rst_led", 64'h0); push("rst_seg", 64'h0); push("rst_lcd_b", 64'h0);
    push("rst_busy", 64'h0);
    check(64'(LED)); check(64'(SEG)); check(lcd_b); check(64'(busy));
    reset = 1'b0;

    // Single write in MANUAL
    mode = 2'd0; wr_addr = 5'd5; wr_data = 8'hA7; wr_en = 1'b1;
    push("w1_reg5", 64'hA7); push("w1_led", 64'hA7); push("w1_pc", 64'd5);
    push("w1_lcd_a", 64'hA7); push("w1_lcd_b", {32'd1, 32'd0});
    step(1);
    check(64'(lcd_registrador[5])); check(64'(LED)); check(64'(lcd_pc));
    check(lcd_a); check(lcd_b);
    wr_en = 1'b0; step(1);

    // Held level counts once; one low cycle re-arms
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 8'h11; step(1);
    wr_data = 8'h22; step(9);
    wr_en = 1'b0; step(1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 8'h33;
    push("hold_reg6", 64'h11); push("hold_reg7", 64'h33); push("hold_led", 64'h33);
    push("hold_lcd_a", 64'h00A7_1133); push("hold_lcd_b", {32'd3, 32'd0});
    step(1);
    check(64'(lcd_registrador[6])); check(64'(lcd_registrador[7])); check(64'(LED));
    check(lcd_a); check(lcd_b);
    wr_en = 1'b0;

    // Auto-scan from 30 with a write on the wrap edge
    wr_addr = 5'd30; push("scan_pre", 64'd30); step(1); check(64'(SEG));
    mode = 2'd1; push("scan_enter", 64'd30); step(1); check(64'(SEG));
    push("scan_div3", 64'd30); step(3); check(64'(SEG));
    push("scan_31", 64'd31); push("scan_31_pc", 64'd31); step(1);
    check(64'(SEG)); check(64'(lcd_pc));
    step(3);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 8'h5A;
    push("scan_wrap0", 64'd0); push("scan_wr_reg9", 64'h5A); step(1);
    check(64'(SEG)); check(64'(lcd_registrador[9]));
    wr_en = 1'b0;
    push("scan_1", 64'd1); step(4); check(64'(SEG));
    mode = 2'd0; push("scan_exit_hold", 64'd1); step(1); check(64'(SEG));
    push("manual_reload", 64'd9); push("manual_led", 64'h5A); step(1);
    check(64'(SEG)); check(64'(LED));

    // Preload top entry, then clear with two writes during it
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 8'hFF; step(1);
    wr_en = 1'b0; step(1);
    mode = 2'd3; nbusy = 0;
    push("clr_busy_cycles", 64'd32); push("clr_all_zero", 64'h0);
    push("clr_lcd_b", {32'd5, 32'd2}); push("clr_lcd_a", 64'h0000_00A7_1133_5AFF);
    push("clr_done_busy", 64'h0);
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (busy) nbusy++;
      if (i == 3 || i == 6) begin
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 8'hEE;
      end else begin
        wr_en = 1'b0;
      end
    end
    orv = or_all();
    check(64'(nbusy)); check(64'(orv)); check(lcd_b); check(lcd_a); check(64'(busy));

    // Freeze drops writes and holds sel
    mode = 2'd2; step(1);
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 8'h44; step(1);
      wr_en = 1'b0; step(1);
    end
    push("frz_reg4", 64'h0); push("frz_lcd_b", {32'd5, 32'd5}); push("frz_seg", 64'd31);
    check(64'(lcd_registrador[4])); check(lcd_b); check(64'(SEG));
    mode = 2'd0; wr_en = 1'b1;
    push("post_frz_reg4", 64'h44); push("post_frz_led", 64'h44);
    push("post_frz_lcd_b", {32'd6, 32'd5}); push("post_frz_lcd_a", 64'h0000_A711_335A_FF44);
    step(1);
    check(64'(lcd_registrador[4])); check(64'(LED)); check(lcd_b); check(lcd_a);
    wr_en = 1'b0;

    // Reset mid-clear, then clear restarts from index 0
    mode = 2'd3; push("clr2_busy", 64'h1); step(1); check(64'(busy));
    step(10);
    reset = 1'b1;
    push("mid_rst_busy", 64'h0); push("mid_rst_lcd_b", 64'h0); push("mid_rst_lcd_a", 64'h0);
    push("mid_rst_seg", 64'h0); push("mid_rst_led", 64'h0);
    #1;
    check(64'(busy)); check(lcd_b); check(lcd_a); check(64'(SEG)); check(64'(LED));
    step(2);
    reset = 1'b0; nbusy = 0;
    push("restart_busy_cycles", 64'd32); push("restart_all_zero", 64'h0);
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (busy) nbusy++;
    end
    orv = or_all();
    check(64'(nbusy)); check(64'(orv));

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
